// File: rtl/noc_vc_bridge.sv
// Packet-granular bridge: one upstream flit stream to VC_NUM downstream virtual channels, round-robin VC allocation per packet.
// Optional NOC_BRIDGE_OREG_EN adds a registered 2-entry skid stage (+1 cycle); default build is a combinational pass-through.
`ifndef Noc_Data_Width
`define Noc_Data_Width 8
`endif

module noc_vc_bridge #(
   parameter int VC_NUM = 2,
   parameter int DATA_W = `Noc_Data_Width
) (
   input  logic                     noc_clk,
   input  logic                     noc_rst_n,
   input  logic                     Noc_receive_valid,
   output logic                     Noc_receive_ready,
   input  logic [DATA_W-1:0]        Noc_receive_flit,
   input  logic                     Noc_receive_is_header,
   input  logic                     Noc_receive_is_tail,
   output logic [VC_NUM-1:0]        Noc_sender_valid,
   input  logic [VC_NUM-1:0]        Noc_sender_ready,
   input  logic [VC_NUM-1:0]        Noc_sender_VCready,
   output logic [VC_NUM*DATA_W-1:0] Noc_sender_flit,
   output logic [VC_NUM-1:0]        Noc_sender_is_header,
   output logic [VC_NUM-1:0]        Noc_sender_is_tail,
   output logic [VC_NUM-1:0]        Noc_bridge_grant,
   output logic                     Noc_bridge_orphan
);

   localparam int IW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     grant_idx;
   logic [VC_NUM-1:0] grant_q;
   logic [IW-1:0]     pick_idx;
   logic              pick_vld;
   logic              alloc;
   logic              release_pkt;
   logic              gnt_rdy;
   logic              idle_drop;

   // First VCready bit at or after the round-robin pointer, wrapping.
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      pick_idx = '0;
      pick_vld = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < VC_NUM; k++) begin
         cand = int'(ptr) + k;
         if (cand >= VC_NUM) cand = cand - VC_NUM;
         cand_idx = IW'(cand);
         if (!pick_vld && Noc_sender_VCready[cand_idx]) begin
            pick_vld = 1'b1;
            pick_idx = cand_idx;
         end
      end
   end

   assign gnt_rdy           = |(grant_q & Noc_sender_ready);
   assign alloc             = (state == IDLE) && Noc_receive_valid && Noc_receive_is_header && pick_vld;
   assign idle_drop         = (state == IDLE) && Noc_receive_valid && !Noc_receive_is_header;
   assign Noc_bridge_orphan = noc_rst_n && idle_drop;
   assign Noc_bridge_grant  = grant_q;

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_idx <= '0;
         grant_q   <= '0;
      end else if (state == IDLE) begin
         if (alloc) begin
            state     <= LOCKED;
            grant_idx <= pick_idx;
            grant_q   <= VC_NUM'(1) << pick_idx;
         end
      end else if (release_pkt) begin
         state   <= IDLE;
         grant_q <= '0;
         ptr     <= (grant_idx == IW'(VC_NUM - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

`ifdef NOC_BRIDGE_OREG_EN
   // Entry word layout: {is_header, is_tail, flit}; entry 0 is the head.
   logic [DATA_W+1:0] skid_q [2];
   logic [1:0]        cnt_q;
   logic [1:0]        cnt_nxt;
   logic              tail_in_q;
   logic              rdy_q;
   logic              in_acc;
   logic              out_acc;
   logic              in_tail;
   logic [DATA_W+1:0] in_word;

   assign in_word     = {Noc_receive_is_header, Noc_receive_is_tail, Noc_receive_flit};
   assign in_acc      = (state == LOCKED) && Noc_receive_valid && rdy_q;
   assign in_tail     = in_acc && Noc_receive_is_tail;
   assign out_acc     = (state == LOCKED) && (cnt_q != 2'd0) && gnt_rdy;
   assign release_pkt = out_acc && skid_q[0][DATA_W];
   assign cnt_nxt     = cnt_q + {1'b0, in_acc} - {1'b0, out_acc};

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         skid_q[0] <= '0;
         skid_q[1] <= '0;
         cnt_q     <= 2'd0;
         tail_in_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         if (out_acc) skid_q[0] <= skid_q[1];
         // Write slot accounts for the head leaving in the same cycle.
         if (in_acc) begin
            if ((cnt_q - {1'b0, out_acc}) == 2'd0) skid_q[0] <= in_word;
            else                                   skid_q[1] <= in_word;
         end
         cnt_q <= cnt_nxt;
         if (release_pkt)  tail_in_q <= 1'b0;
         else if (in_tail) tail_in_q <= 1'b1;
         rdy_q <= (alloc || ((state == LOCKED) && !release_pkt)) &&
                  !(tail_in_q || in_tail) && (cnt_nxt < 2'd2);
      end
   end

   always_comb begin
      Noc_receive_ready = 1'b0;
      if (noc_rst_n) Noc_receive_ready = (state == LOCKED) ? rdy_q : idle_drop;
   end

   always_comb begin
      Noc_sender_valid     = '0;
      Noc_sender_flit      = '0;
      Noc_sender_is_header = '0;
      Noc_sender_is_tail   = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         if (grant_q[i]) begin
            Noc_sender_valid[i]               = (cnt_q != 2'd0);
            Noc_sender_flit[i*DATA_W +: DATA_W] = skid_q[0][DATA_W-1:0];
            Noc_sender_is_tail[i]             = skid_q[0][DATA_W];
            Noc_sender_is_header[i]           = skid_q[0][DATA_W+1];
         end
      end
   end
`else
   assign release_pkt = (state == LOCKED) && Noc_receive_valid && gnt_rdy && Noc_receive_is_tail;

   always_comb begin
      Noc_receive_ready = 1'b0;
      if (noc_rst_n) Noc_receive_ready = (state == LOCKED) ? gnt_rdy : idle_drop;
   end

   // grant_q is zero in IDLE, so non-owning VCs and the idle state both drive 0.
   always_comb begin
      Noc_sender_valid     = '0;
      Noc_sender_flit      = '0;
      Noc_sender_is_header = '0;
      Noc_sender_is_tail   = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         if (grant_q[i]) begin
            Noc_sender_valid[i]               = Noc_receive_valid;
            Noc_sender_flit[i*DATA_W +: DATA_W] = Noc_receive_flit;
            Noc_sender_is_header[i]           = Noc_receive_is_header;
            Noc_sender_is_tail[i]             = Noc_receive_is_tail;
         end
      end
   end
`endif

endmodule

// File: tb/tb_noc_vc_bridge.sv
// Directed bench for noc_vc_bridge (VC_NUM=2, DATA_W=8): allocation, round-robin, stalls, orphan drop, mid-packet reset.
module tb_noc_vc_bridge;

   logic        noc_clk;
   logic        noc_rst_n;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  rx_flit;
   logic        rx_hdr;
   logic        rx_tail;
   logic [1:0]  tx_valid;
   logic [1:0]  tx_ready;
   logic [1:0]  tx_vcready;
   logic [15:0] tx_flit;
   logic [1:0]  tx_hdr;
   logic [1:0]  tx_tail;
   logic [1:0]  grant;
   logic        orphan;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [7:0] exp0 [5];
   logic [7:0] exp1 [5];

   noc_vc_bridge #(.VC_NUM(2), .DATA_W(8)) dut (
      .noc_clk              (noc_clk),
      .noc_rst_n            (noc_rst_n),
      .Noc_receive_valid    (rx_valid),
      .Noc_receive_ready    (rx_ready),
      .Noc_receive_flit     (rx_flit),
      .Noc_receive_is_header(rx_hdr),
      .Noc_receive_is_tail  (rx_tail),
      .Noc_sender_valid     (tx_valid),
      .Noc_sender_ready     (tx_ready),
      .Noc_sender_VCready   (tx_vcready),
      .Noc_sender_flit      (tx_flit),
      .Noc_sender_is_header (tx_hdr),
      .Noc_sender_is_tail   (tx_tail),
      .Noc_bridge_grant     (grant),
      .Noc_bridge_orphan    (orphan)
   );

   initial noc_clk = 1'b0;
   always #5 noc_clk = ~noc_clk;

   // Record every downstream handshake per VC.
   always @(posedge noc_clk) begin
      if (tx_valid[0] && tx_ready[0]) q0.push_back(tx_flit[7:0]);
      if (tx_valid[1] && tx_ready[1]) q1.push_back(tx_flit[15:8]);
   end

   task automatic tick();
      @(posedge noc_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] f, input logic h, input logic t);
      rx_valid = v;
      rx_flit  = f;
      rx_hdr   = h;
      rx_tail  = t;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      noc_rst_n  = 1'b0;
      tx_ready   = 2'b11;
      tx_vcready = 2'b11;
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      #1;
      // Reset holds every output low even with a non-header flit offered.
      chk("rst_ready", rx_ready, 0);
      chk("rst_orphan", orphan, 0);
      chk("rst_grant", grant, 0);
      chk("rst_valid", tx_valid, 0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      noc_rst_n = 1'b1;
      tick();

      // 3-flit packet onto VC0
      drive(1'b1, 8'hA1, 1'b1, 1'b0);
      #1;
      chk("a_alloc_ready", rx_ready, 0);
      chk("a_alloc_grant", grant, 0);
      chk("a_alloc_valid", tx_valid, 0);
      tick();
      chk("a_grant", grant, 2'b01);
      chk("a1_valid", tx_valid, 2'b01);
      chk("a1_flit", tx_flit[7:0], 8'hA1);
      chk("a1_hdr", tx_hdr, 2'b01);
      chk("a1_ready", rx_ready, 1);
      tick();
      drive(1'b1, 8'hA2, 1'b0, 1'b0);
      #1;
      chk("a2_flit", tx_flit[7:0], 8'hA2);
      chk("a2_hdr", tx_hdr, 2'b00);
      tick();
      drive(1'b1, 8'hA3, 1'b0, 1'b1);
      #1;
      chk("a3_tail", tx_tail, 2'b01);
      chk("a3_flit", tx_flit[7:0], 8'hA3);
      tick();

      // Single-flit packet: round-robin moves to VC1
      drive(1'b1, 8'hB1, 1'b1, 1'b1);
      #1;
      chk("b_idle_grant", grant, 0);
      chk("b_idle_ready", rx_ready, 0);
      tick();
      chk("b_grant", grant, 2'b10);
      chk("b_valid", tx_valid, 2'b10);
      chk("b_flit", tx_flit[15:8], 8'hB1);
      chk("b_ready", rx_ready, 1);
      tick();

      // No VC available for 5 cycles, then only VC1
      tx_vcready = 2'b00;
      drive(1'b1, 8'hC1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("c_wait_ready", rx_ready, 0);
         chk("c_wait_grant", grant, 0);
         tick();
      end
      tx_vcready = 2'b10;
      #1;
      chk("c_alloc_ready", rx_ready, 0);
      tick();
      chk("c_grant", grant, 2'b10);
      // VCready flips and VC1 stalls mid-packet
      tx_vcready = 2'b01;
      tx_ready   = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("c_stall_ready", rx_ready, 0);
         chk("c_stall_grant", grant, 2'b10);
         chk("c_stall_flit", tx_flit[15:8], 8'hC1);
         tick();
      end
      tx_ready = 2'b11;
      #1;
      chk("c_resume_ready", rx_ready, 1);
      tick();
      drive(1'b1, 8'hC2, 1'b0, 1'b1);
      #1;
      chk("c2_valid", tx_valid, 2'b10);
      tick();

      // Orphan non-header flit in IDLE
      tx_vcready = 2'b11;
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      #1;
      chk("o_ready", rx_ready, 1);
      chk("o_orphan", orphan, 1);
      chk("o_valid", tx_valid, 0);
      chk("o_grant", grant, 0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      chk("o_orphan_end", orphan, 0);
      chk("o_ready_end", rx_ready, 0);

      // Single flit on VC0 moves pointer to 1
      drive(1'b1, 8'hE1, 1'b1, 1'b1);
      tick();
      chk("e_grant", grant, 2'b01);
      tick();

      // 4-flit packet on VC1, reset after 2nd flit
      drive(1'b1, 8'hD1, 1'b1, 1'b0);
      tick();
      chk("d_grant", grant, 2'b10);
      tick();
      drive(1'b1, 8'hD2, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'hD3, 1'b0, 1'b0);
      #1;
      chk("d3_valid_pre", tx_valid, 2'b10);
      noc_rst_n = 1'b0;
      #1;
      chk("d_rst_ready", rx_ready, 0);
      chk("d_rst_valid", tx_valid, 0);
      chk("d_rst_flit", tx_flit, 0);
      chk("d_rst_grant", grant, 0);
      chk("d_rst_orphan", orphan, 0);
      tick();
      noc_rst_n = 1'b1;
      drive(1'b1, 8'hF1, 1'b1, 1'b1);
      #1;
      chk("f_alloc_ready", rx_ready, 0);
      tick();
      chk("f_grant_vc0", grant, 2'b01);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("f_idle_grant", grant, 0);

      exp0 = '{8'hA1, 8'hA2, 8'hA3, 8'hE1, 8'hF1};
      exp1 = '{8'hB1, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
      chk("q0_size", q0.size(), 5);
      chk("q1_size", q1.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("q0_flit", (i < q0.size()) ? {24'h0, q0[i]} : 32'hFFFF_FFFF, {24'h0, exp0[i]});
         chk("q1_flit", (i < q1.size()) ? {24'h0, q1[i]} : 32'hFFFF_FFFF, {24'h0, exp1[i]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_vc_bridge.md
NOC_VC_BRIDGE -- requirements
Module: noc_vc_bridge

Interface
REQ-001 SHALL have parameter VC_NUM, default 2: number of downstream virtual channels (2..8).
REQ-002 SHALL have parameter DATA_W, default `Noc_Data_Width: flit width in bits.
REQ-003 SHALL have port noc_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port noc_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Noc_receive_valid  input  1  upstream flit valid.
REQ-006 SHALL have port Noc_receive_ready  output  1  upstream flit accepted when valid&ready.
REQ-007 SHALL have port Noc_receive_flit  input  DATA_W  upstream flit.
REQ-008 SHALL have port Noc_receive_is_header / Noc_receive_is_tail  input  1 each  packet delimiters; both high means single-flit packet.
REQ-009 SHALL have port Noc_sender_valid  output  VC_NUM  per-VC flit valid.
REQ-010 SHALL have port Noc_sender_ready  input  VC_NUM  per-VC flit ready.
REQ-011 SHALL have port Noc_sender_VCready  input  VC_NUM  per-VC "can accept a new packet".
REQ-012 SHALL have port Noc_sender_flit  output  VC_NUM*DATA_W  per-VC flit, VC i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port Noc_sender_is_header / Noc_sender_is_tail  output  VC_NUM each  per-VC delimiters.
REQ-014 SHALL have port Noc_bridge_grant  output  VC_NUM  one-hot VC currently owning the packet, 0 when idle.
REQ-015 SHALL have port Noc_bridge_orphan  output  1  one-cycle pulse when a non-header flit is dropped in IDLE.

Function
REQ-016 SHALL implement two states: IDLE (no VC owned) and LOCKED (one VC owns the packet).
REQ-017 In IDLE, Noc_receive_ready SHALL be 0 while a header is presented and no VC is allocated.
REQ-018 In IDLE with valid&is_header and any VCready bit set, SHALL grant the first set VCready bit at or after the round-robin pointer (wrapping modulo VC_NUM) and enter LOCKED next cycle (1-cycle allocation latency, header not consumed in the allocation cycle).
REQ-019 In IDLE with valid&is_header and VCready all 0, SHALL stay in IDLE, ready 0, and retry each cycle.
REQ-020 In IDLE with valid and is_header=0, SHALL set ready=1, drop the flit, and pulse Noc_bridge_orphan for that cycle.
REQ-021 In LOCKED, the granted VC SHALL receive valid/flit/is_header/is_tail from upstream and Noc_receive_ready SHALL equal its Noc_sender_ready; all other VCs SHALL drive valid, flit, header, tail as 0.
REQ-022 VCready changes during LOCKED SHALL NOT alter the grant.
REQ-023 On valid&ready&is_tail in LOCKED, SHALL return to IDLE next cycle and set the pointer to (grant index + 1) mod VC_NUM.
REQ-024 A single-flit packet SHALL allocate, transfer in one handshake, and return to IDLE, i.e. 2 cycles per packet minimum.
REQ-025 Noc_bridge_grant SHALL be one-hot in LOCKED and 0 in IDLE; never more than one bit set.

Reset
REQ-026 On noc_rst_n low, state SHALL be IDLE, pointer 0, grant 0, and every output 0 (Noc_receive_ready 0, all sender outputs 0, orphan 0), including mid-packet; the partial packet is abandoned.

Configuration
REQ-027 Macro NOC_BRIDGE_OREG_EN defined: SHALL insert a 2-entry skid buffer per bridge between upstream and the granted VC, so sender outputs are registered (+1 cycle latency), Noc_receive_ready is registered and full throughput is kept; return to IDLE waits until the tail leaves the buffer; reset empties the buffer.
REQ-028 Macro NOC_BRIDGE_OREG_EN undefined: SHALL use the combinational pass-through path of REQ-021 with zero added latency.

Verification
REQ-029 VC_NUM=2, VCready=2'b11, 3-flit packet 0xA1,0xA2,0xA3 -> grant=2'b01, the flits appear on VC0 in order, tail returns the block to IDLE, pointer=1.
REQ-030 Second packet immediately after REQ-029 with VCready=2'b11 -> grant=2'b10 (round-robin), VC0 valid stays 0.
REQ-031 VCready=0 for 5 cycles with a header pending, then VCready=2'b10 -> ready 0 for 5 cycles, then grant=2'b10 one cycle later.
REQ-032 Noc_sender_ready of the granted VC low for 3 cycles mid-packet -> upstream ready 0 for those cycles, no flit lost or duplicated.
REQ-033 Non-header flit 0x55 presented in IDLE -> ready=1, orphan pulses once, and no sender valid is asserted.
REQ-034 Reset asserted after the 2nd of 4 flits -> all outputs 0 immediately, grant 0, and the next header is allocated from VC0.
